// File: rtl/car_sensor_pkg.sv
// Shared types and constants for the country-road loop-detector front-end.
// State encoding, signal colour codes and default timing parameters.
package car_sensor_pkg;

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StQualOn  = 2'd1,
        StOnLoop  = 2'd2,
        StQualOff = 2'd3
    } det_state_e;

    // Colour codes on the controller's cntry/hwy outputs
    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    localparam int unsigned DEBOUNCE_DEF = 4;
    localparam int unsigned CNT_W_DEF    = 4;
    localparam int unsigned HOLD_DEF     = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser and debounce FSM for the loop detector.
// Emits single-cycle arrive/depart strobes, valid in the cycle before the accepting edge.
module sync_debounce
    import car_sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clock,
    input  logic clear,
    input  logic sensor,
    output logic arrive,
    output logic depart
);

    localparam logic [3:0] DCNT_LAST = 4'(DEBOUNCE - 1);

    logic       sync1_q, sync1_d;
    logic       sensor_s_q, sensor_s_d;
    logic [3:0] dcnt_q, dcnt_d;
    det_state_e state_q, state_d;
    logic       acc_lvl;

    always_comb begin
        sync1_d    = sensor;
        sensor_s_d = sync1_q;
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        arrive     = 1'b0;
        depart     = 1'b0;
        acc_lvl    = (state_q == StOnLoop) || (state_q == StQualOff);

        if (sensor_s_q == acc_lvl) begin
            dcnt_d  = 4'd0;
            state_d = acc_lvl ? StOnLoop : StEmpty;
        end else if (dcnt_q == DCNT_LAST) begin
            // Level has differed for DEBOUNCE consecutive cycles: accept it
            dcnt_d  = 4'd0;
            state_d = acc_lvl ? StEmpty : StOnLoop;
            arrive  = !acc_lvl;
            depart  = acc_lvl;
        end else begin
            dcnt_d  = dcnt_q + 4'd1;
            state_d = acc_lvl ? StQualOff : StQualOn;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sync1_q    <= 1'b0;
            sensor_s_q <= 1'b0;
            dcnt_q     <= 4'd0;
            state_q    <= StEmpty;
        end else begin
            sync1_q    <= sync1_d;
            sensor_s_q <= sensor_s_d;
            dcnt_q     <= dcnt_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: rtl/car_sensor_cond.sv
// Country-road car-present conditioner: queue counter, sticky overflow and registered X.
// Build option X_HOLD_EN stretches X for HOLD cycles after the queue empties.
module car_sensor_cond
    import car_sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned HOLD     = HOLD_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             sensor,
    input  logic             cntry_green,
    output logic             X,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             arrive, depart;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             x_q, x_d;

    sync_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_sync_debounce (
        .clock  (clock),
        .clear  (clear),
        .sensor (sensor),
        .arrive (arrive),
        .depart (depart)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (arrive) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (depart && cntry_green && (count_q != '0)) begin
            // Cars creeping over the loop on red stay queued
            count_d = count_q - CNT_W'(1);
        end
    end

`ifdef X_HOLD_EN
    localparam int unsigned HOLD_W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (arrive) begin
            hold_d = '0;
        end else if ((count_q != '0) && (count_d == '0)) begin
            hold_d = HOLD_W'(HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
        x_d = (count_d != '0) || (hold_d != '0);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    always_comb begin
        x_d = (count_d != '0);
    end
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            x_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            x_q     <= x_d;
        end
    end

    assign X         = x_q;
    assign car_count = count_q;
    assign overflow  = ovf_q;

endmodule
